// File: rtl/pipe_inst_buf_pkg.sv
// Shared sizing constants for the IF->ID instruction queue.
package pipe_inst_buf_pkg;

    localparam int unsigned IBUF_DEPTH = 4;
    localparam int unsigned IBUF_PTR_L = 2;

endpackage

// File: rtl/pipe_buf_mem.sv
// DEPTH x DATA_L register array: one synchronous write port, one async read port, no reset.
module pipe_buf_mem
    import pipe_inst_buf_pkg::*;
#(
    parameter int unsigned DEPTH  = IBUF_DEPTH,
    parameter int unsigned PTR_L  = IBUF_PTR_L,
    parameter int unsigned DATA_L = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_L-1:0]  wr_addr,
    input  logic [DATA_L-1:0] wr_data,
    input  logic [PTR_L-1:0]  rd_addr,
    output logic [DATA_L-1:0] rd_data
);

    logic [DATA_L-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/pipe_inst_buf.sv
// Instruction queue between IF and ID: one write per buf_we assertion, show-ahead read,
// purge drops every queued entry.
module pipe_inst_buf
    import pipe_inst_buf_pkg::*;
#(
    parameter int unsigned INST_L = 32,
    parameter int unsigned PC_L   = 32,
    parameter int unsigned DEPTH  = IBUF_DEPTH,
    parameter int unsigned PTR_L  = IBUF_PTR_L,
    parameter int unsigned CNT_L  = PTR_L + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              buf_we,
    input  logic [INST_L-1:0] inst_in,
    input  logic [PC_L-1:0]   pc_in,
    output logic              buf_wack,
    output logic              buf_f,
    input  logic              purge,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INST_L-1:0] id_inst,
    output logic [PC_L-1:0]   id_pc,
    output logic [CNT_L-1:0]  count
);

    logic [PTR_L-1:0]       r_rd_ptr, r_wr_ptr;
    logic [CNT_L-1:0]       r_count;
    logic                   r_armed;
    logic                   r_wack;
    logic                   r_full;

    logic                   w_req;
    logic                   w_full;
    logic                   w_ack;
    logic                   w_wr;
    logic                   w_rd;
    logic [CNT_L-1:0]       w_count_d;
    logic [INST_L+PC_L-1:0] w_head;

    assign w_full = (r_count == CNT_L'(DEPTH));
    assign w_req  = buf_we & r_armed;
    // Purge acknowledges any armed request so IF never stalls across a redirect.
    assign w_ack  = w_req & (purge | ~w_full);
    assign w_wr   = w_ack & ~purge;
    assign w_rd   = id_valid & id_ready & ~purge;

    always_comb begin
        w_count_d = r_count;
        if (purge) begin
            w_count_d = '0;
        end else if (w_wr && !w_rd) begin
            w_count_d = r_count + CNT_L'(1);
        end else if (w_rd && !w_wr) begin
            w_count_d = r_count - CNT_L'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_armed  <= 1'b1;
            r_wack   <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            r_count <= w_count_d;
            r_full  <= (w_count_d == CNT_L'(DEPTH));
            r_wack  <= w_ack;
            if (!buf_we) begin
                r_armed <= 1'b1;
            end else if (w_ack) begin
                r_armed <= 1'b0;
            end
            if (purge) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_L'(1);
                if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_L'(1);
            end
        end
    end

    pipe_buf_mem #(
        .DEPTH  (DEPTH),
        .PTR_L  (PTR_L),
        .DATA_L (INST_L + PC_L)
    ) u_mem (
        .clk     (clk),
        .we      (w_wr),
        .wr_addr (r_wr_ptr),
        .wr_data ({inst_in, pc_in}),
        .rd_addr (r_rd_ptr),
        .rd_data (w_head)
    );

    assign id_valid = (r_count != '0);
    assign id_inst  = id_valid ? w_head[INST_L+PC_L-1:PC_L] : '0;
    assign id_pc    = id_valid ? w_head[PC_L-1:0] : '0;
    assign count    = r_count;
    assign buf_wack = r_wack;
    assign buf_f    = r_full;

endmodule
